// File: rtl/regbus_pkg.sv
// Shared widths and encodings for the codec register-bus arbiter.
package regbus_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        ACK
    } state_t;

    // One-hot {B,A}; zero means the bus is idle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10
    } owner_t;

endpackage

// File: rtl/regbus_arb_sel.sv
// Owner selection for the register bus: A has priority, but B wins once A has
// taken MAX_STREAK consecutive grants while B was waiting.
module regbus_arb_sel
    import regbus_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   req_a,
    input  logic   req_b,
    input  logic   grantNow,
    output owner_t sel
);

    localparam int unsigned      CNT_W      = $clog2(MAX_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);

    logic [CNT_W-1:0] streak;
    logic             bTurn;

    always_comb begin
        bTurn = req_b && (streak == STREAK_MAX);
        sel   = OWN_NONE;
        if (req_a && !bTurn) begin
            sel = OWN_A;
        end else if (req_b) begin
            sel = OWN_B;
        end
    end

    // Only IDLE cycles count: a cleared req_b or a B grant restarts the streak.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grantNow) begin
            if (!req_b || sel == OWN_B) begin
                streak <= '0;
            end else if (sel == OWN_A && streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbus_arb.sv
// Two-master arbiter/sequencer for the codec control-register bus: serialises
// single-word reads and writes from ports A and B onto one slave bus.
module regbus_arb
    import regbus_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_a,
    input  logic              wr_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdat_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdat_a,

    input  logic              req_b,
    input  logic              wr_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdat_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdat_b,

    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdat,
    input  logic [DATA_W-1:0] rdat,
    output logic [1:0]        gnt
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t     state;
    state_t     nextState;
    owner_t     sel;
    owner_t     owner;
    logic       selWr;
    logic [2:0] latCnt;

    regbus_arb_sel #(
        .MAX_STREAK(MAX_STREAK)
    ) u_sel (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .grantNow(state == IDLE),
        .sel     (sel)
    );

    assign gnt = owner;

    always_comb begin
        selWr = (sel == OWN_B) ? wr_b : wr_a;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (sel != OWN_NONE) nextState = selWr ? WR : RD;
            WR:      nextState = ACK;
            RD:      if (latCnt == '0) nextState = ACK;
            ACK:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Every output is a register; ack is set on the edge that enters ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            we     <= 1'b0;
            addr   <= '0;
            wdat   <= '0;
            owner  <= OWN_NONE;
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            rdat_a <= '0;
            rdat_b <= '0;
            latCnt <= '0;
        end else begin
            we    <= 1'b0;
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel != OWN_NONE) begin
                        owner  <= sel;
                        we     <= selWr;
                        latCnt <= LAT_LOAD;
                        if (sel == OWN_B) begin
                            addr <= addr_b;
                            wdat <= wdat_b;
                        end else begin
                            addr <= addr_a;
                            wdat <= wdat_a;
                        end
                    end
                end
                WR: begin
                    ack_a <= (owner == OWN_A);
                    ack_b <= (owner == OWN_B);
                end
                RD: begin
                    if (latCnt == '0) begin
                        if (owner == OWN_B) begin
                            rdat_b <= rdat;
                            ack_b  <= 1'b1;
                        end else begin
                            rdat_a <= rdat;
                            ack_a  <= 1'b1;
                        end
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                ACK: begin
                    owner <= OWN_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_arb.sv
// Bench for regbus_arb: cycle table on an RD_LAT=1 instance, plus hand-written
// starvation, mid-read reset and read-latency sequences (RD_LAT=3 instance).
module tb_regbus_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // RD_LAT=1 instance
    logic        rst1;
    logic        reqA, wrA, reqB, wrB;
    logic [6:0]  addrA, addrB;
    logic [31:0] wdatA, wdatB, slv;
    logic        ackA, ackB, we;
    logic [31:0] rdatA, rdatB, wdat;
    logic [6:0]  addr;
    logic [1:0]  gnt;

    // RD_LAT=3 instance
    logic        rst3;
    logic        r3ReqA, r3WrA, r3ReqB, r3WrB;
    logic [6:0]  r3AddrA, r3AddrB;
    logic [31:0] r3WdatA, r3WdatB, r3Slv;
    logic        r3AckA, r3AckB, r3We;
    logic [31:0] r3RdatA, r3RdatB, r3Wdat;
    logic [6:0]  r3Addr;
    logic [1:0]  r3Gnt;

    regbus_arb #(.RD_LAT(1), .MAX_STREAK(4)) u1 (
        .clk(clk), .rst(rst1),
        .req_a(reqA), .wr_a(wrA), .addr_a(addrA), .wdat_a(wdatA), .ack_a(ackA), .rdat_a(rdatA),
        .req_b(reqB), .wr_b(wrB), .addr_b(addrB), .wdat_b(wdatB), .ack_b(ackB), .rdat_b(rdatB),
        .we(we), .addr(addr), .wdat(wdat), .rdat(slv), .gnt(gnt)
    );

    regbus_arb #(.RD_LAT(3), .MAX_STREAK(4)) u3 (
        .clk(clk), .rst(rst3),
        .req_a(r3ReqA), .wr_a(r3WrA), .addr_a(r3AddrA), .wdat_a(r3WdatA), .ack_a(r3AckA), .rdat_a(r3RdatA),
        .req_b(r3ReqB), .wr_b(r3WrB), .addr_b(r3AddrB), .wdat_b(r3WdatB), .ack_b(r3AckB), .rdat_b(r3RdatB),
        .we(r3We), .addr(r3Addr), .wdat(r3Wdat), .rdat(r3Slv), .gnt(r3Gnt)
    );

    typedef struct {
        logic        reqA;
        logic        wrA;
        logic [6:0]  addrA;
        logic [31:0] wdatA;
        logic        reqB;
        logic        wrB;
        logic [6:0]  addrB;
        logic [31:0] wdatB;
        logic [31:0] slv;
        logic        eWe;
        logic [6:0]  eAddr;
        logic [31:0] eWdat;
        logic [1:0]  eGnt;
        logic        eAckA;
        logic        eAckB;
        logic [31:0] eRdatA;
        logic [31:0] eRdatB;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vec [NVEC];

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset1(input string tag);
        check({tag, " we"},    32'(we),    32'h0);
        check({tag, " addr"},  32'(addr),  32'h0);
        check({tag, " wdat"},  wdat,       32'h0);
        check({tag, " gnt"},   32'(gnt),   32'h0);
        check({tag, " ackA"},  32'(ackA),  32'h0);
        check({tag, " ackB"},  32'(ackB),  32'h0);
        check({tag, " rdatA"}, rdatA,      32'h0);
        check({tag, " rdatB"}, rdatB,      32'h0);
    endtask

    task automatic checkReset3(input string tag);
        check({tag, " we"},    32'(r3We),    32'h0);
        check({tag, " addr"},  32'(r3Addr),  32'h0);
        check({tag, " wdat"},  r3Wdat,       32'h0);
        check({tag, " gnt"},   32'(r3Gnt),   32'h0);
        check({tag, " ackA"},  32'(r3AckA),  32'h0);
        check({tag, " ackB"},  32'(r3AckB),  32'h0);
        check({tag, " rdatA"}, r3RdatA,      32'h0);
        check({tag, " rdatB"}, r3RdatB,      32'h0);
    endtask

    initial begin
        logic [1:0] grants [10];
        logic [1:0] expGrants [10];
        logic [1:0] prevGnt;
        int         nGrant;

        // Rows: inputs during cycle i, expected outputs after the edge ending cycle i.
        //           reqA  wrA   addrA  wdatA          reqB  wrB   addrB  wdatB          slv
        //           we    addr   wdat           gnt    ackA  ackB  rdatA  rdatB
        vec[0]  = '{1'b1, 1'b1, 7'h12, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00, 32'h00000000, 32'h0,
                    1'b1, 7'h12, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0};
        vec[1]  = '{1'b1, 1'b1, 7'h12, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00, 32'h00000000, 32'h0,
                    1'b0, 7'h12, 32'hDEADBEEF, 2'b01, 1'b1, 1'b0, 32'h0, 32'h0};
        vec[2]  = '{1'b1, 1'b1, 7'h12, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00, 32'h00000000, 32'h0,
                    1'b0, 7'h12, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
        vec[3]  = '{1'b0, 1'b1, 7'h12, 32'hDEADBEEF, 1'b1, 1'b0, 7'h05, 32'h11111111, 32'h0,
                    1'b0, 7'h05, 32'h11111111, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0};
        vec[4]  = '{1'b0, 1'b1, 7'h12, 32'hDEADBEEF, 1'b1, 1'b0, 7'h05, 32'h11111111, 32'h000000A5,
                    1'b0, 7'h05, 32'h11111111, 2'b10, 1'b0, 1'b1, 32'h0, 32'h000000A5};
        vec[5]  = '{1'b0, 1'b1, 7'h12, 32'hDEADBEEF, 1'b1, 1'b0, 7'h05, 32'h11111111, 32'hFFFFFFFF,
                    1'b0, 7'h05, 32'h11111111, 2'b00, 1'b0, 1'b0, 32'h0, 32'h000000A5};
        vec[6]  = '{1'b1, 1'b1, 7'h20, 32'hCAFEF00D, 1'b1, 1'b1, 7'h30, 32'h0BADF00D, 32'h0,
                    1'b1, 7'h20, 32'hCAFEF00D, 2'b01, 1'b0, 1'b0, 32'h0, 32'h000000A5};
        vec[7]  = '{1'b1, 1'b1, 7'h20, 32'hCAFEF00D, 1'b1, 1'b1, 7'h30, 32'h0BADF00D, 32'h0,
                    1'b0, 7'h20, 32'hCAFEF00D, 2'b01, 1'b1, 1'b0, 32'h0, 32'h000000A5};
        vec[8]  = '{1'b1, 1'b1, 7'h20, 32'hCAFEF00D, 1'b1, 1'b1, 7'h30, 32'h0BADF00D, 32'h0,
                    1'b0, 7'h20, 32'hCAFEF00D, 2'b00, 1'b0, 1'b0, 32'h0, 32'h000000A5};
        vec[9]  = '{1'b0, 1'b1, 7'h20, 32'hCAFEF00D, 1'b1, 1'b1, 7'h30, 32'h0BADF00D, 32'h0,
                    1'b1, 7'h30, 32'h0BADF00D, 2'b10, 1'b0, 1'b0, 32'h0, 32'h000000A5};
        vec[10] = '{1'b0, 1'b1, 7'h20, 32'hCAFEF00D, 1'b1, 1'b1, 7'h30, 32'h0BADF00D, 32'h0,
                    1'b0, 7'h30, 32'h0BADF00D, 2'b10, 1'b0, 1'b1, 32'h0, 32'h000000A5};
        vec[11] = '{1'b0, 1'b1, 7'h20, 32'hCAFEF00D, 1'b1, 1'b1, 7'h30, 32'h0BADF00D, 32'h0,
                    1'b0, 7'h30, 32'h0BADF00D, 2'b00, 1'b0, 1'b0, 32'h0, 32'h000000A5};
        vec[12] = '{1'b0, 1'b1, 7'h20, 32'hCAFEF00D, 1'b0, 1'b1, 7'h30, 32'h0BADF00D, 32'h0,
                    1'b0, 7'h30, 32'h0BADF00D, 2'b00, 1'b0, 1'b0, 32'h0, 32'h000000A5};

        expGrants = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        rst1 = 1'b1; rst3 = 1'b1;
        reqA = 1'b0; wrA = 1'b0; addrA = '0; wdatA = '0;
        reqB = 1'b0; wrB = 1'b0; addrB = '0; wdatB = '0; slv = '0;
        r3ReqA = 1'b0; r3WrA = 1'b0; r3AddrA = '0; r3WdatA = '0;
        r3ReqB = 1'b0; r3WrB = 1'b0; r3AddrB = '0; r3WdatB = '0; r3Slv = '0;

        tick();
        tick();
        checkReset1("rst1");
        checkReset3("rst3");
        rst1 = 1'b0; rst3 = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            reqA = vec[i].reqA; wrA = vec[i].wrA; addrA = vec[i].addrA; wdatA = vec[i].wdatA;
            reqB = vec[i].reqB; wrB = vec[i].wrB; addrB = vec[i].addrB; wdatB = vec[i].wdatB;
            slv  = vec[i].slv;
            tick();
            check($sformatf("v%0d we", i),    32'(we),    32'(vec[i].eWe));
            check($sformatf("v%0d addr", i),  32'(addr),  32'(vec[i].eAddr));
            check($sformatf("v%0d wdat", i),  wdat,       vec[i].eWdat);
            check($sformatf("v%0d gnt", i),   32'(gnt),   32'(vec[i].eGnt));
            check($sformatf("v%0d ackA", i),  32'(ackA),  32'(vec[i].eAckA));
            check($sformatf("v%0d ackB", i),  32'(ackB),  32'(vec[i].eAckB));
            check($sformatf("v%0d rdatA", i), rdatA,      vec[i].eRdatA);
            check($sformatf("v%0d rdatB", i), rdatB,      vec[i].eRdatB);
        end

        // Starvation guard: A writes back-to-back while B keeps requesting.
        reqA = 1'b1; wrA = 1'b1; addrA = 7'h40; wdatA = 32'h1;
        reqB = 1'b1; wrB = 1'b1; addrB = 7'h41; wdatB = 32'h2;
        nGrant  = 0;
        prevGnt = gnt;
        for (int c = 0; c < 60 && nGrant < 10; c++) begin
            tick();
            if (gnt != 2'b00 && prevGnt == 2'b00) begin
                grants[nGrant] = gnt;
                nGrant++;
            end
            prevGnt = gnt;
        end
        check("streak grant count", 32'(nGrant), 32'd10);
        for (int g = 0; g < 10; g++) begin
            if (g < nGrant) check($sformatf("streak grant %0d", g), 32'(grants[g]), 32'(expGrants[g]));
        end
        reqA = 1'b0;
        tick();
        reqB = 1'b0;
        tick();
        tick();
        check("post-streak gnt", 32'(gnt), 32'h0);

        // Mid-read reset on the RD_LAT=3 instance: rst during N+2.
        r3ReqA = 1'b1; r3WrA = 1'b0; r3AddrA = 7'h33; r3Slv = 32'h00001234;
        tick();
        check("mr N+1 addr", 32'(r3Addr), 32'h33);
        check("mr N+1 gnt",  32'(r3Gnt),  32'h1);
        check("mr N+1 we",   32'(r3We),   32'h0);
        tick();
        check("mr N+2 ackA", 32'(r3AckA), 32'h0);
        rst3 = 1'b1; r3ReqA = 1'b0;
        tick();
        checkReset3("mr N+3");
        rst3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mr idle%0d ackA", k), 32'(r3AckA), 32'h0);
            check($sformatf("mr idle%0d gnt", k),  32'(r3Gnt),  32'h0);
            check($sformatf("mr idle%0d we", k),   32'(r3We),   32'h0);
        end

        // Read of 0x7F with RD_LAT=3 after the reset.
        r3ReqA = 1'b1; r3WrA = 1'b0; r3AddrA = 7'h7F; r3Slv = 32'h55AA00FF;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("rl N+%0d addr", k), 32'(r3Addr), 32'h7F);
            check($sformatf("rl N+%0d ackA", k), 32'(r3AckA), 32'h0);
            check($sformatf("rl N+%0d we", k),   32'(r3We),   32'h0);
            check($sformatf("rl N+%0d gnt", k),  32'(r3Gnt),  32'h1);
        end
        tick();
        check("rl N+4 ackA",  32'(r3AckA), 32'h1);
        check("rl N+4 rdatA", r3RdatA,     32'h55AA00FF);
        check("rl N+4 ackB",  32'(r3AckB), 32'h0);
        r3Slv = 32'hDEAD0000; r3ReqA = 1'b0;
        tick();
        check("rl N+5 ackA",  32'(r3AckA), 32'h0);
        check("rl N+5 rdatA", r3RdatA,     32'h55AA00FF);
        check("rl N+5 gnt",   32'(r3Gnt),  32'h0);
        tick();
        check("rl N+6 rdatA", r3RdatA,     32'h55AA00FF);
        check("rl N+6 rdatB", r3RdatB,     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regbus_arb.md
# regbus_arb

Two-master arbiter and sequencer for the 7-bit-address / 32-bit-data register bus that feeds the codec's control registers. Port A is the host command path and has priority. Port B is an on-chip master, such as a codec init or housekeeping sequencer. The block serialises their single-word reads and writes onto one slave bus, generates the one-cycle write strobe, times read capture, and prevents starvation of port B.

## Interface
Parameters:
- RD_LAT, 1: slave read latency in cycles from address valid to rdat valid; legal range 1..7.
- MAX_STREAK, 4: maximum consecutive A grants while B is waiting; legal range ≥1.

Ports (`x` = `a` or `b`; the group below appears once per port):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_x  in  1  transaction request; held until ack_x.
- wr_x  in  1  1 = write, 0 = read; stable while req_x is high.
- addr_x  in  7  register address; stable while req_x is high.
- wdat_x  in  32  write data; stable while req_x is high.
- ack_x  out  1  one-cycle completion pulse.
- rdat_x  out  32  read result; valid from the ack_x cycle and held until the next read ack on that port.

Slave bus and status:
- we  out  1  slave write strobe, one cycle per write.
- addr  out  7  slave address.
- wdat  out  32  slave write data.
- rdat  in  32  slave read data.
- gnt  out  2  current owner, one-hot {B,A}; 00 when idle.

## Operation
- FSM states:
  - IDLE: sample req_a/req_b, select the owner, and register wr/addr/wdat into the bus registers and gnt. Next state is WR or RD, or stay in IDLE if no request.
  - WR: we=1 for exactly this cycle, then go to ACK.
  - RD: we=0, addr held; a down-counter loaded with RD_LAT-1. In the final RD cycle (counter=0), latch rdat into rdat_owner, then go to ACK.
  - ACK: ack_owner=1 for this cycle; gnt cleared on exit; go to IDLE.
- Grant rule in IDLE:
  - Only one requester: grant it.
  - Both requesting: grant A, unless streak==MAX_STREAK, in which case grant B.
- streak counter:
  - Increments on each A grant made while req_b=1.
  - Clears on any B grant and on any IDLE cycle with req_b=0.
  - Saturates at MAX_STREAK.
- addr and wdat keep their last values after a transaction; they are not zeroed.
- A write never updates rdat_x.
- A requester must drop req_x, or present a new transaction, in the cycle after ack_x. IDLE sampling req on that cycle is legal and starts a new transaction.
- Reset, including mid-transaction:
  - state=IDLE; we=0, addr=0, wdat=0, ack_a=ack_b=0, rdat_a=rdat_b=0, gnt=00, streak=0.
  - The in-flight transaction is dropped with no ack and no we.

## Timing
Cycle N is the IDLE cycle that samples req.
- Write: gnt, addr and wdat valid at N+1; we=1 at N+1 only; ack at N+2. Period is 3 cycles back-to-back.
- Read: addr valid N+1..N+RD_LAT; rdat sampled at the end of N+RD_LAT; ack with rdat_x valid at N+RD_LAT+1. Period is RD_LAT+2 cycles.
- There is no combinational path from req_x, wr_x, addr_x or wdat_x to any output; all outputs are registered.
- A request that rises during a non-IDLE state waits; the losing requester is serviced in the first IDLE after the current ACK.

## Structure
- Shared package regbus_pkg:
  - ADDR_W=7, DATA_W=32.
  - FSM state encoding: IDLE, WR, RD, ACK.
  - Owner encoding: one-hot {B,A}.
- One sub-module, regbus_arb_sel: owns the streak counter and the IDLE-time priority decision. Inputs are req_a, req_b and a "grant now" strobe; the output is the one-hot select.
- The top-level holds the FSM, the RD_LAT counter, the bus registers and the per-port rdat registers.

## Test plan
- Write, A only: A writes 0x12 / 0xDEADBEEF. Required: we=1 only at N+1, with addr=0x12 and wdat=0xDEADBEEF; ack_a at N+2; ack_b never; gnt=01 for N+1..N+2.
- Read, B, RD_LAT=1: B reads 0x05 and the slave returns 0x000000A5. Required: addr=0x05 at N+1 with we=0; ack_b at N+2 with rdat_b=0x000000A5; rdat_a remains 0.
- Simultaneous request: A and B request in the same cycle. Required: A completes first; B is granted in the IDLE immediately after ack_a; each ack pulses exactly once.
- Starvation guard, MAX_STREAK=4: A issues back-to-back writes with req_b held high. Required: grant sequence A,A,A,A,B,A,A,A,A,B.
- Mid-read reset, RD_LAT=3: assert rst at N+2. Required: next cycle all outputs at reset values; no ack; a read issued after rst drops acks at N'+4 with correct data.
- Read latency, RD_LAT=3: read of 0x7F. Required: addr held N+1..N+3; ack at N+4; slave data changes after N+3 do not alter rdat_x.
